// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcode, FSM state and flag index definitions for ex_unit
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_NOR = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_LHB = 4'd7,
        OP_LLB = 4'd8,
        OP_MUL = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // flags port layout is {N,Z,V}
    localparam int FLAG_V = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

endpackage

// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module ex_mul_seq
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] partial;

    // Accumulator plus the current partial product; on the last step this is the final product,
    // so the caller can register it on the same edge that finishes the iteration.
    assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = partial;
    assign done    = (cnt_q == CW'(1));

    // Load operands on start, otherwise consume one multiplier bit per cycle until the count drains
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - CW'(1);
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Iteration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - execute unit with handshake, saturating ADD/SUB and optional MUL (EX_UNIT_MUL_EN)
module ex_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [WIDTH-1:0] imm,
    input  logic             a_sel,
    input  logic             b_sel,
    input  logic [3:0]       alu_op,
    input  logic [SHW-1:0]   sh_amt,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;

    logic [WIDTH-1:0] a_op, b_op, sum, diff, alu_res;
    logic             alu_v, keep_flags, accept;

    function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] r, input logic v);
        logic [2:0] f;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_V] = v;
        return f;
    endfunction

    assign a_op      = a_sel ? pc : reg1;
    assign b_op      = b_sel ? reg2 : imm;
    assign sum       = a_op + b_op;
    assign diff      = a_op - b_op;
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign flags     = flags_q;

`ifdef EX_UNIT_MUL_EN
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_sf_q, mul_sf_d;

    ex_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_op),
        .b       (b_op),
        .done    (mul_done),
        .product (mul_product)
    );

    // set_flags is sampled at acceptance because the inputs move on while the multiply runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mul_sf_q <= 1'b0;
        else     mul_sf_q <= mul_sf_d;
    end
`endif

    // Single-cycle datapath; ADD/SUB saturate toward the sign of A on signed overflow
    always_comb begin
        alu_res    = a_op;
        alu_v      = 1'b0;
        keep_flags = 1'b0;
        case (alu_op)
            OP_ADD: begin
                if ((a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1])) begin
                    alu_res = a_op[WIDTH-1] ? MIN_NEG : MAX_POS;
                    alu_v   = 1'b1;
                end else begin
                    alu_res = sum;
                end
            end
            OP_SUB: begin
                if ((a_op[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != a_op[WIDTH-1])) begin
                    alu_res = a_op[WIDTH-1] ? MIN_NEG : MAX_POS;
                    alu_v   = 1'b1;
                end else begin
                    alu_res = diff;
                end
            end
            OP_AND: alu_res = a_op & b_op;
            OP_NOR: alu_res = ~(a_op | b_op);
            OP_SLL: alu_res = a_op << sh_amt;
            OP_SRL: alu_res = a_op >> sh_amt;
            OP_SRA: alu_res = $signed(a_op) >>> sh_amt;
            OP_LHB: alu_res = WIDTH'({b_op[HALF-1:0], a_op[HALF-1:0]});
            OP_LLB: alu_res = {a_op[WIDTH-1:HALF], b_op[HALF-1:0]};
            // Without the multiplier this is a plain pass of A; with it the flags come from the product
            OP_MUL: keep_flags = 1'b1;
            default: alu_res = a_op;
        endcase
    end

    // Next-state: accept in IDLE or while the held result is consumed, wait for the multiplier in BUSY
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef EX_UNIT_MUL_EN
        mul_start = 1'b0;
        mul_sf_d  = mul_sf_q;
`endif
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    state_d  = ST_HOLD;
                    result_d = alu_res;
                    if (set_flags && !keep_flags) begin
                        flags_d = flags_of(alu_res, alu_v);
                    end
`ifdef EX_UNIT_MUL_EN
                    if (alu_op == OP_MUL) begin
                        state_d   = ST_BUSY;
                        result_d  = result_q;
                        mul_start = 1'b1;
                        mul_sf_d  = set_flags;
                    end
`endif
                end
            end
`ifdef EX_UNIT_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_HOLD;
                    result_d = mul_product;
                    if (mul_sf_q) begin
                        flags_d = flags_of(mul_product, 1'b0);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, result and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= 3'b000;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal range 8 to 32.
REQ-002 Parameter SHW, default 4: shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port in_valid, input, 1: operation presented.
REQ-006 Port in_ready, output, 1: unit accepts an operation this cycle.
REQ-007 Port pc, input, WIDTH: program counter for PC-relative ops.
REQ-008 Port reg1, input, WIDTH: first register operand.
REQ-009 Port reg2, input, WIDTH: second register operand.
REQ-010 Port imm, input, WIDTH: sign-extended immediate or offset from decode.
REQ-011 Port a_sel, input, 1: 1 selects pc as operand A, 0 selects reg1.
REQ-012 Port b_sel, input, 1: 1 selects reg2 as operand B, 0 selects imm.
REQ-013 Port alu_op, input, 4: operation code.
REQ-014 Port sh_amt, input, SHW: shift amount.
REQ-015 Port set_flags, input, 1: the operation updates the flag register.
REQ-016 Port out_valid, output, 1: result held on result/flags.
REQ-017 Port out_ready, input, 1: downstream consumes the result.
REQ-018 Port result, output, WIDTH: registered result.
REQ-019 Port flags, output, 3: registered {N,Z,V}.

Function
REQ-020 Operations: 0 ADD, 1 SUB (A-B), 2 AND, 3 NOR, 4 SLL, 5 SRL, 6 SRA, 7 LHB {B[W/2-1:0],A[W/2-1:0]}, 8 LLB {A[W-1:W/2],B[W/2-1:0]}, 9 MUL (low WIDTH bits of A*B), 10-15 pass A.
REQ-021 Handshake: an operation transfers when in_valid and in_ready are both high; a result is consumed when out_valid and out_ready are both high.
REQ-022 FSM states: IDLE, BUSY, HOLD.
REQ-023 IDLE: in_ready=1; a single-cycle op (not MUL) goes to HOLD, and a MUL goes to BUSY.
REQ-024 Single-cycle latency: result and flags are registered on the accepting edge; out_valid=1 from the next cycle.
REQ-025 BUSY: shift-add multiply, one bit per cycle, exactly WIDTH cycles; in_ready=0; the unit then enters HOLD.
REQ-026 HOLD: out_valid=1 and result/flags stable until consumed.
REQ-027 In HOLD, if out_ready=1 the unit simultaneously accepts a new valid op (in_ready=out_ready); otherwise it stays in HOLD.
REQ-028 V is set only for ADD/SUB signed overflow; ADD/SUB saturate to the most positive or most negative value on overflow.
REQ-029 Z is set when result==0; N equals result[WIDTH-1].
REQ-030 When set_flags=0, the flags register keeps its prior value.
REQ-031 MUL sets Z and N and clears V.
REQ-032 sh_amt=0 returns A unchanged; SRA fills with A[WIDTH-1].

Reset
REQ-033 Reset: state=IDLE, result=0, flags=3'b000, out_valid=0, in_ready=1 while rst is high.
REQ-034 Reset asserted during BUSY or HOLD discards the operation; no out_valid pulse follows release.

Configuration
REQ-035 With EX_UNIT_MUL_EN defined, MUL behaves per REQ-025.
REQ-036 Without EX_UNIT_MUL_EN, op 9 is a single-cycle pass of A with flags unchanged, and BUSY is unreachable.

Structure
REQ-037 Package ex_pkg holds the alu_op enum, the FSM state typedef and the flag bit indices.
REQ-038 Sub-module ex_mul_seq (iterative multiplier with start/done) is instantiated only under EX_UNIT_MUL_EN.

Verification
REQ-039 ADD: A=16'h7FFF, B=16'h0001, set_flags=1 -> result 16'h7FFF, flags N=0 Z=0 V=1, out_valid the next cycle.
REQ-040 SUB: A=5, B=5 -> result 0, Z=1; then AND with set_flags=0 -> flags still Z=1.
REQ-041 MUL (EX_UNIT_MUL_EN): A=16'h0012, B=16'h0034 -> result 16'h03A8, in_ready=0 for 16 cycles, out_valid on cycle 17.
REQ-042 Back-pressure: out_ready=0 for 3 cycles -> result held and in_ready=0; then out_ready=1 with a new op -> consume and accept in the same cycle.
REQ-043 rst pulsed mid-MUL at cycle 5 -> outputs return to reset values, with no spurious out_valid afterwards.
REQ-044 SRA: A=16'h8000, sh_amt=15 -> result 16'hFFFF, N=1.
